// File: rtl/output_layer_mac.sv
// Output-layer neuron array: streams activations and weight rows and accumulates
// ten neurons in parallel. The bias row follows the last activation row.
module output_layer_mac #(
  parameter int N_HIDDEN = 32,
  parameter int ADDR_W   = 6,
  parameter int A_W      = 8,
  parameter int W_W      = 8,
  parameter int S_W      = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic signed [A_W-1:0] act_data,
  input  logic [10*W_W-1:0]     w_data,
  output logic                  out_valid,
  output logic signed [S_W-1:0] s0,
  output logic signed [S_W-1:0] s1,
  output logic signed [S_W-1:0] s2,
  output logic signed [S_W-1:0] s3,
  output logic signed [S_W-1:0] s4,
  output logic signed [S_W-1:0] s5,
  output logic signed [S_W-1:0] s6,
  output logic signed [S_W-1:0] s7,
  output logic signed [S_W-1:0] s8,
  output logic signed [S_W-1:0] s9
);

  localparam logic [ADDR_W-1:0] BIAS_ROW = ADDR_W'(N_HIDDEN);
  localparam int P_W = A_W + W_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic                  vld_d1;
  logic                  bias_d1;
  logic signed [S_W-1:0] acc      [10];
  logic signed [S_W-1:0] acc_next [10];
  logic signed [S_W-1:0] score    [10];

  for (genvar j = 0; j < 10; j++) begin : g_neuron
    logic signed [W_W-1:0] w;
    logic signed [P_W-1:0] prod;
    assign w    = w_data[W_W*j +: W_W];
    assign prod = P_W'(act_data) * P_W'(w);
    assign acc_next[j] = !vld_d1 ? acc[j] :
                         bias_d1 ? acc[j] + S_W'(w) :
                                   acc[j] + S_W'(prod);
  end

  // DRAIN publishes acc_next directly so the bias row lands in the same
  // edge that raises out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      vld_d1    <= 1'b0;
      bias_d1   <= 1'b0;
      for (int j = 0; j < 10; j++) begin
        acc[j]   <= '0;
        score[j] <= '0;
      end
    end else begin
      vld_d1    <= rd_en;
      bias_d1   <= rd_en && (rd_addr == BIAS_ROW);
      out_valid <= 1'b0;
      for (int j = 0; j < 10; j++) acc[j] <= acc_next[j];
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            for (int j = 0; j < 10; j++) acc[j] <= '0;
          end
        end
        RUN: begin
          if (rd_addr == BIAS_ROW) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
          for (int j = 0; j < 10; j++) score[j] <= acc_next[j];
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s0 = score[0];
  assign s1 = score[1];
  assign s2 = score[2];
  assign s3 = score[3];
  assign s4 = score[4];
  assign s5 = score[5];
  assign s6 = score[6];
  assign s7 = score[7];
  assign s8 = score[8];
  assign s9 = score[9];

endmodule
